// File: rtl/card_dealer.sv
// card_dealer - deals 5 distinct cards from a 32-card deck using a 16-bit LFSR with linear probing.
// Optional feature macro: DEALER_DECK_PERSIST_EN keeps the used-card mask across hands.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        deal_req,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [5:0]  hand [4:0],
  output logic        hand_valid,
  input  logic        hand_ready,
  output logic        busy
`ifdef DEALER_DECK_PERSIST_EN
  ,
  output logic        deck_reshuffled
`endif
);

  typedef enum logic [1:0] {IDLE, DRAW, PRESENT} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [31:0] used;
  logic [2:0]  idx;
  logic        retry;
  logic [4:0]  cand;
  logic [4:0]  probe;
  logic        hit;
  logic        start;
  logic        fill;
`ifdef DEALER_DECK_PERSIST_EN
  logic [5:0]  used_cnt;
`endif

  // A retry probe walks linearly from the colliding card instead of using the LFSR.
  always_comb begin
    probe     = retry ? cand : lfsr[4:0];
    hit       = used[probe];
    start     = (state == IDLE) && deal_req;
    fill      = (state == DRAW) && !hit;
    state_nxt = state;
    case (state)
      IDLE:    if (deal_req) state_nxt = DRAW;
      DRAW:    if (fill && idx == 3'd4) state_nxt = PRESENT;
      PRESENT: if (hand_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hand_valid = (state == PRESENT);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr  <= LFSR_SEED;
      used  <= '0;
      idx   <= '0;
      retry <= 1'b0;
      cand  <= '0;
      for (int i = 0; i < 5; i++) hand[i] <= '0;
`ifdef DEALER_DECK_PERSIST_EN
      used_cnt        <= '0;
      deck_reshuffled <= 1'b0;
`endif
    end else begin
      if (seed_load)           lfsr <= (seed == 16'h0) ? 16'hACE1 : seed;
      else if (state == DRAW)  lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`ifdef DEALER_DECK_PERSIST_EN
      deck_reshuffled <= 1'b0;
`endif
      if (start) begin
        idx   <= '0;
        retry <= 1'b0;
        for (int i = 0; i < 5; i++) hand[i] <= '0;
`ifdef DEALER_DECK_PERSIST_EN
        // Fewer than five cards left: start over with a full deck.
        if (used_cnt >= 6'd28) begin
          used            <= '0;
          used_cnt        <= '0;
          deck_reshuffled <= 1'b1;
        end
`else
        used <= '0;
`endif
      end else if (state == DRAW) begin
        if (hit) begin
          retry <= 1'b1;
          cand  <= probe + 5'd1;
        end else begin
          for (int i = 0; i < 5; i++)
            if (idx == 3'(i)) hand[i] <= {probe, 1'b1};
          used[probe] <= 1'b1;
          idx         <= idx + 3'd1;
          retry       <= 1'b0;
`ifdef DEALER_DECK_PERSIST_EN
          used_cnt    <= used_cnt + 6'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer - randomized self-checking bench for card_dealer against a deck-level model.
module tb_card_dealer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        deal_req;
  logic        seed_load;
  logic [15:0] seed;
  logic [5:0]  hand [4:0];
  logic        hand_valid;
  logic        hand_ready;
  logic        busy;
`ifdef DEALER_DECK_PERSIST_EN
  logic        deck_reshuffled;
`endif

  card_dealer #(.LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .deal_req(deal_req), .seed_load(seed_load), .seed(seed),
    .hand(hand), .hand_valid(hand_valid), .hand_ready(hand_ready), .busy(busy)
`ifdef DEALER_DECK_PERSIST_EN
    , .deck_reshuffled(deck_reshuffled)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Deck model: LFSR state, which cards are out, and the last expected hand
  logic [15:0] m_lfsr;
  bit          m_used [32];
  int          m_cnt;
  logic [4:0]  m_hand [5];
  int          m_probes;
  bit          m_resh;
  logic [5:0]  g_hand [5];
  logic [5:0]  first  [5];
  bit          seen   [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic void model_reset();
    m_lfsr = 16'hACE1;
    foreach (m_used[i]) m_used[i] = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void model_deal();
    int c;
    m_resh = 1'b0;
`ifdef DEALER_DECK_PERSIST_EN
    if (32 - m_cnt < 5) begin
      foreach (m_used[i]) m_used[i] = 1'b0;
      m_cnt  = 0;
      m_resh = 1'b1;
    end
`else
    foreach (m_used[i]) m_used[i] = 1'b0;
`endif
    m_probes = 0;
    for (int k = 0; k < 5; k++) begin
      c = int'(m_lfsr % 32);
      m_lfsr = lfsr_step(m_lfsr);
      m_probes++;
      while (m_used[c]) begin
        c = (c + 1) % 32;
        m_lfsr = lfsr_step(m_lfsr);
        m_probes++;
      end
      m_used[c] = 1'b1;
      m_cnt++;
      m_hand[k] = 5'(c);
    end
  endfunction

  task automatic load_seed(input logic [15:0] s);
    @(negedge clk);
    seed = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_hand(input int hold, input bit pulse_mid);
    int cnt;
    int dup;
    model_deal();
    hand_ready = (hold == 0);
    @(negedge clk);
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
`ifdef DEALER_DECK_PERSIST_EN
    check("reshuffle", deck_reshuffled, m_resh);
`endif
    cnt = 0;
    while (!hand_valid && cnt < 200) begin
      deal_req = pulse_mid && (cnt == 1 || cnt == 2);
      @(negedge clk);
      cnt++;
`ifdef DEALER_DECK_PERSIST_EN
      if (cnt == 1) check("reshuffle_pulse_end", deck_reshuffled, 0);
`endif
    end
    deal_req = 1'b0;
    check("draw_cycles", cnt, m_probes);
    check("draw_in_range", (cnt >= 5 && cnt <= 160), 1);
    check("busy_present", busy, 1);
    dup = 0;
    for (int k = 0; k < 5; k++) begin
      g_hand[k] = hand[k];
      check("card", hand[k], {m_hand[k], 1'b1});
      for (int j = 0; j < k; j++) if (hand[j] == hand[k]) dup++;
    end
    check("distinct", dup, 0);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", hand_valid, 1);
        for (int k = 0; k < 5; k++) check("hold_card", hand[k], g_hand[k]);
      end
      hand_ready = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", hand_valid, 0);
    check("idle_after_xfer", busy, 0);
    hand_ready = 1'b0;
    @(negedge clk);
    check("stay_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [15:0] s;
    rst_n = 1'b0; deal_req = 1'b0; seed_load = 1'b0; seed = '0; hand_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", hand_valid, 0);
    check("rst_busy", busy, 0);
    for (int k = 0; k < 5; k++) check("rst_hand", hand[k], 0);
`ifdef DEALER_DECK_PERSIST_EN
    check("rst_reshuffled", deck_reshuffled, 0);
`endif
    rst_n = 1'b1;

    run_hand(0, 0);
    run_hand(20, 0);

    load_seed(16'h0);
    run_hand(0, 0);
    s = 16'($urandom_range(1, 65535));
    load_seed(s);
    run_hand(1, 0);
    for (int k = 0; k < 5; k++) first[k] = g_hand[k];
    load_seed(s);
    run_hand(2, 0);
`ifndef DEALER_DECK_PERSIST_EN
    for (int k = 0; k < 5; k++) check("same_seed", g_hand[k], first[k]);
`endif

    run_hand(3, 1);

    // Abort a hand after two cards are drawn
    @(negedge clk);
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    cnt = 0;
    while (hand[1][0] !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_wait", (cnt < 200), 1);
    for (int k = 2; k < 5; k++) check("unfilled_slot", hand[k], 0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", hand_valid, 0);
    for (int k = 0; k < 5; k++) check("abort_hand", hand[k], 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_hand(0, 0);

    for (int h = 0; h < 8; h++) begin
      if ($urandom_range(0, 2) == 0) load_seed(16'($urandom));
      run_hand(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

`ifdef DEALER_DECK_PERSIST_EN
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    for (int h = 0; h < 6; h++) begin
      run_hand(int'($urandom_range(0, 3)), 1'b0);
      for (int k = 0; k < 5; k++) seen[g_hand[k][5:1]] = 1'b1;
    end
    cnt = 0;
    foreach (seen[i]) if (seen[i]) cnt++;
    check("deck_30_distinct", cnt, 30);
    run_hand(0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, the LFSR value after reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port deal_req  input  1  request to deal one 5-card hand; sampled only in IDLE.
REQ-005 SHALL have port seed_load  input  1  when high, loads seed into the LFSR on this clock edge.
REQ-006 SHALL have port seed  input  16  new LFSR value; a value of 0 is replaced by 16'hACE1.
REQ-007 SHALL have port hand  output  6x5 (unpacked [4:0] of [5:0])  dealt cards; each card is {rank[5:3], suit[2:1], valid[0]}.
REQ-008 SHALL have port hand_valid  output  1  hand is complete and held stable.
REQ-009 SHALL have port hand_ready  input  1  consumer accepts the hand.
REQ-010 SHALL have port busy  output  1  high in DRAW and PRESENT.
REQ-011 SHALL have port deck_reshuffled  output  1  one-cycle pulse when the used mask is cleared; present only with DEALER_DECK_PERSIST_EN.

Function
REQ-012 SHALL map deck index c[4:0] (32 cards) to card {c[4:2], c[1:0], 1'b1}; the card valid bit is always 1 on dealt cards.
REQ-013 SHALL implement a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing one step every DRAW cycle and holding in other states.
REQ-014 SHALL implement FSM IDLE -> DRAW on deal_req; DRAW -> PRESENT when slot 4 is filled; PRESENT -> IDLE on hand_valid && hand_ready.
REQ-015 SHALL, in DRAW on a fresh probe, take candidate = lfsr[4:0]; on a collision with the used mask, it SHALL take candidate+1 mod 32 next cycle without consulting the LFSR.
REQ-016 SHALL, for a candidate not in the used mask, write it to slot idx (0..4 in order), set its mask bit, increment idx, and take the next candidate fresh from the LFSR.
REQ-017 SHALL guarantee five distinct cards per hand, with a worst-case DRAW duration of 5 x 32 cycles and a minimum of 5 cycles.
REQ-018 SHALL assert hand_valid only in PRESENT, and SHALL keep hand[4:0] unchanged from DRAW exit until the handshake completes.
REQ-019 SHALL drive hand_valid low on the cycle after the transfer, and SHALL require at least one IDLE cycle before the next DRAW.
REQ-020 SHALL ignore deal_req in DRAW and PRESENT; deal_req held high in IDLE starts exactly one hand per IDLE visit.
REQ-021 SHALL make seed_load override the LFSR step in the same cycle and be legal in any state; a hand in progress continues with the new sequence.
REQ-022 SHALL hold hand slots not yet filled at 6'b0, with valid bit 0.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force: state=IDLE, lfsr=LFSR_SEED, used mask=0, idx=0, hand all 6'b0, hand_valid=0, busy=0, deck_reshuffled=0.
REQ-024 SHALL abort a DRAW or PRESENT on reset mid-operation, discard the partial hand, and start from IDLE after rst_n deasserts.

Configuration
REQ-025 SHALL support macro DEALER_DECK_PERSIST_EN.
REQ-026 SHALL, without the macro, clear the used mask on entry to DRAW, so every hand is drawn from a full 32-card deck, and SHALL tie deck_reshuffled to 0.
REQ-027 SHALL, with the macro, keep the used mask across hands, so cards are not repeated until a reshuffle.
REQ-028 SHALL, with the macro, clear the mask and pulse deck_reshuffled on the IDLE->DRAW transition when fewer than 5 cards remain, i.e. after 6 hands (2 cards left).

Verification
REQ-029 SHALL test: reset, LFSR_SEED=16'hACE1, deal_req 1 cycle, hand_ready=1 -> hand_valid within 5..160 cycles, 5 distinct cards, all bit0=1.
REQ-030 SHALL test: hand_ready=0 for 20 cycles in PRESENT -> hand stable, hand_valid high; hand_ready=1 -> hand_valid low next cycle, state IDLE.
REQ-031 SHALL test: seed_load with seed=0 -> LFSR=16'hACE1; two runs with the same seed -> identical hands.
REQ-032 SHALL test: deal_req pulsed during DRAW -> ignored; exactly one hand delivered.
REQ-033 SHALL test: rst_n low after 2 cards drawn -> outputs reset values immediately; a new deal afterwards yields a full valid hand.
REQ-034 SHALL test, with DEALER_DECK_PERSIST_EN: 6 hands -> 30 distinct cards; 7th deal_req -> deck_reshuffled one-cycle pulse, then a valid hand.
